clint: RTL and testbench

- Core-local interrupt/exception sequencer for the 5-stage RV32I pipeline.
- Watches the instruction in EX and the machine timer interrupt line, and decides on trap entry or mret.
- Holds the pipeline via hold_flag_o, which feeds the controller's hold input (currently unconnected).
- Performs the mepc/mcause/mstatus CSR writes over a dedicated CSR write port. That port has priority over EX's port inside csr.
- Ends each sequence with a one-cycle redirect pulse to the controller.

---
 rtl/clint_pkg.sv | 46 ++++
 rtl/clint.sv | 130 +++++++++++++
 tb/tb_clint.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared CSR addresses, cause codes, bit indices and FSM states for clint
package clint_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_MTIMER = 32'h8000_0007;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEPC    = 3'd1,
        S_MCAUSE  = 3'd2,
        S_MSTATUS = 3'd3,
        S_ASSERT  = 3'd4,
        S_MRET    = 3'd5
    } state_t;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[12:11]        = 2'b11;
        return r;
    endfunction

    // mret: MIE <= MPIE, MPIE <= 1.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint.sv
// rtl/clint.sv - trap/mret sequencer driving CSR writes, pipeline hold and redirect pulse
// Optional: CLINT_VECTORED_EN enables vectored mtvec targets for asynchronous traps.
module clint
    import clint_pkg::*;
#(
    parameter logic RESET_MIE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_ecall_i,
    input  logic        ex_ebreak_i,
    input  logic        ex_mret_i,
    input  logic        irq_timer_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mie_i,
    output logic        hold_flag_o,
    output logic        clint_csr_we_o,
    output logic [11:0] clint_csr_waddr_o,
    output logic [31:0] clint_csr_wdata_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    state_t      state_q, state_d;
    logic [31:0] epc_q, cause_q;
    logic        mret_q, async_q;
    logic        det_sync, det_ret, det_async, det_any;
    logic [31:0] trap_target;
    logic        unused_ok;

    // Detection is gated by rst_n so every output is 0 while reset is held.
    assign det_sync  = rst_n & ex_valid_i & (ex_ecall_i | ex_ebreak_i);
    assign det_ret   = rst_n & ex_valid_i & ex_mret_i;
    assign det_async = rst_n & ex_valid_i & irq_timer_i
                     & csr_mstatus_i[MSTATUS_MIE] & csr_mie_i[MIE_MTIE];
    assign det_any   = det_sync | det_ret | det_async;

    assign unused_ok = ^{csr_mie_i[31:MIE_MTIE+1], csr_mie_i[MIE_MTIE-1:0],
                         csr_mtvec_i[1:0], RESET_MIE};

    always_comb begin
        trap_target = {csr_mtvec_i[31:2], 2'b00};
`ifdef CLINT_VECTORED_EN
        if (async_q && csr_mtvec_i[1:0] == 2'b01)
            trap_target = {csr_mtvec_i[31:2], 2'b00} + {cause_q[29:0], 2'b00};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            mret_q  <= 1'b0;
            async_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && det_any) begin
                epc_q   <= ex_pc_i;
                mret_q  <= ~det_sync & det_ret;
                async_q <= ~det_sync & ~det_ret;
                if (det_sync)
                    cause_q <= ex_ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
                else if (!det_ret)
                    cause_q <= CAUSE_MTIMER;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        hold_flag_o       = 1'b0;
        clint_csr_we_o    = 1'b0;
        clint_csr_waddr_o = '0;
        clint_csr_wdata_o = '0;
        int_assert_o      = 1'b0;
        int_addr_o        = '0;
        case (state_q)
            S_IDLE: begin
                if (det_sync || (det_async && !det_ret)) begin
                    hold_flag_o = 1'b1;
                    state_d     = S_MEPC;
                end else if (det_ret) begin
                    hold_flag_o = 1'b1;
                    state_d     = S_MRET;
                end
            end
            S_MEPC: begin
                hold_flag_o       = 1'b1;
                clint_csr_we_o    = 1'b1;
                clint_csr_waddr_o = CSR_MEPC;
                clint_csr_wdata_o = epc_q;
                state_d           = S_MCAUSE;
            end
            S_MCAUSE: begin
                hold_flag_o       = 1'b1;
                clint_csr_we_o    = 1'b1;
                clint_csr_waddr_o = CSR_MCAUSE;
                clint_csr_wdata_o = cause_q;
                state_d           = S_MSTATUS;
            end
            S_MSTATUS: begin
                hold_flag_o       = 1'b1;
                clint_csr_we_o    = 1'b1;
                clint_csr_waddr_o = CSR_MSTATUS;
                clint_csr_wdata_o = trap_mstatus(csr_mstatus_i);
                state_d           = S_ASSERT;
            end
            S_MRET: begin
                hold_flag_o       = 1'b1;
                clint_csr_we_o    = 1'b1;
                clint_csr_waddr_o = CSR_MSTATUS;
                clint_csr_wdata_o = mret_mstatus(csr_mstatus_i);
                state_d           = S_ASSERT;
            end
            S_ASSERT: begin
                hold_flag_o  = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = mret_q ? csr_mepc_i : trap_target;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_clint.sv
// tb/tb_clint.sv - self-checking bench for clint: vector table, corner sequences, randomized events
module tb_clint;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i, ex_ecall_i, ex_ebreak_i, ex_mret_i, irq_timer_i;
    logic [31:0] ex_pc_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i, csr_mie_i;
    logic        hold_flag_o, clint_csr_we_o, int_assert_o;
    logic [11:0] clint_csr_waddr_o;
    logic [31:0] clint_csr_wdata_o, int_addr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clint dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_valid_i        (ex_valid_i),
        .ex_pc_i           (ex_pc_i),
        .ex_ecall_i        (ex_ecall_i),
        .ex_ebreak_i       (ex_ebreak_i),
        .ex_mret_i         (ex_mret_i),
        .irq_timer_i       (irq_timer_i),
        .csr_mtvec_i       (csr_mtvec_i),
        .csr_mepc_i        (csr_mepc_i),
        .csr_mstatus_i     (csr_mstatus_i),
        .csr_mie_i         (csr_mie_i),
        .hold_flag_o       (hold_flag_o),
        .clint_csr_we_o    (clint_csr_we_o),
        .clint_csr_waddr_o (clint_csr_waddr_o),
        .clint_csr_wdata_o (clint_csr_wdata_o),
        .int_assert_o      (int_assert_o),
        .int_addr_o        (int_addr_o)
    );

    // kind: 0 none, 1 ecall, 2 ebreak, 3 mret, 4 timer
    typedef struct {
        logic        valid, ecall, ebreak, mret, irq;
        logic [31:0] pc, ms, mie, mtvec, mepc;
        int          kind;
    } vec_t;

    typedef struct {
        logic        hold, we, asrt;
        logic [11:0] waddr;
        logic [31:0] wdata, addr;
    } cyc_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic ec, input logic eb, input logic mr,
                                input logic irq, input logic [31:0] pc, input logic [31:0] ms,
                                input logic [31:0] mie, input logic [31:0] mtvec,
                                input logic [31:0] mepc, input int kind);
        vec_t r;
        r.valid = v; r.ecall = ec; r.ebreak = eb; r.mret = mr; r.irq = irq;
        r.pc = pc; r.ms = ms; r.mie = mie; r.mtvec = mtvec; r.mepc = mepc; r.kind = kind;
        return r;
    endfunction

    function automatic cyc_t blank();
        cyc_t c;
        c.hold = 0; c.we = 0; c.asrt = 0; c.waddr = 0; c.wdata = 0; c.addr = 0;
        return c;
    endfunction

    function automatic int classify(input vec_t v);
        if (!v.valid) return 0;
        if (v.ecall) return 1;
        if (v.ebreak) return 2;
        if (v.mret) return 3;
        if (v.irq && v.ms[3] && v.mie[7]) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] mtvec, input int kind);
        logic [31:0] t;
        t = mtvec & 32'hFFFF_FFFC;
`ifdef CLINT_VECTORED_EN
        if (kind == 4 && (mtvec & 32'h3) == 32'h1) t = t + 32'h1C;
`endif
        return t;
    endfunction

    task automatic apply(input vec_t v);
        ex_valid_i = v.valid; ex_ecall_i = v.ecall; ex_ebreak_i = v.ebreak;
        ex_mret_i = v.mret; irq_timer_i = v.irq; ex_pc_i = v.pc;
        csr_mstatus_i = v.ms; csr_mie_i = v.mie; csr_mtvec_i = v.mtvec; csr_mepc_i = v.mepc;
    endtask

    task automatic run_event(input vec_t v, input int kind, input string tag);
        cyc_t        exp[$];
        cyc_t        c;
        logic [31:0] cause;
        c = blank(); c.hold = (kind != 0); exp.push_back(c);
        if (kind == 1 || kind == 2 || kind == 4) begin
            cause = (kind == 1) ? 32'd11 : (kind == 2) ? 32'd3 : 32'h8000_0007;
            c = blank(); c.hold = 1; c.we = 1;
            c.waddr = 12'h341; c.wdata = v.pc; exp.push_back(c);
            c.waddr = 12'h342; c.wdata = cause; exp.push_back(c);
            c.waddr = 12'h300;
            c.wdata = (v.ms & ~32'h88) | (v.ms[3] ? 32'h80 : 32'h0) | 32'h1800;
            exp.push_back(c);
            c = blank(); c.hold = 1; c.asrt = 1; c.addr = target(v.mtvec, kind); exp.push_back(c);
        end else if (kind == 3) begin
            c = blank(); c.hold = 1; c.we = 1; c.waddr = 12'h300;
            c.wdata = (v.ms & ~32'h8) | (v.ms[7] ? 32'h8 : 32'h0) | 32'h80;
            exp.push_back(c);
            c = blank(); c.hold = 1; c.asrt = 1; c.addr = v.mepc; exp.push_back(c);
        end
        exp.push_back(blank());

        @(posedge clk); #1;
        apply(v);
        for (int i = 0; i < exp.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d_ctrl", tag, i), {hold_flag_o, clint_csr_we_o, int_assert_o},
                  {exp[i].hold, exp[i].we, exp[i].asrt});
            if (exp[i].we)
                check($sformatf("%s_c%0d_wr", tag, i), {clint_csr_waddr_o, clint_csr_wdata_o},
                      {exp[i].waddr, exp[i].wdata});
            if (exp[i].asrt)
                check($sformatf("%s_c%0d_addr", tag, i), int_addr_o, exp[i].addr);
            if (i == exp.size() - 1) break;
            @(posedge clk); #1;
            if (i + 1 < exp.size() - 1) begin
                // busy states must ignore whatever EX presents
                ex_valid_i = 1'($urandom); ex_ecall_i = 1'($urandom);
                ex_ebreak_i = 1'($urandom); ex_mret_i = 1'($urandom);
                irq_timer_i = 1'($urandom); ex_pc_i = $urandom;
            end else begin
                ex_valid_i = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        check("reset_outs", {hold_flag_o, clint_csr_we_o, int_assert_o, clint_csr_waddr_o,
                             clint_csr_wdata_o}, '0);
        check("reset_addr", int_addr_o, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //         v  ec eb mr irq pc          ms          mie         mtvec       mepc       kind
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h40,  32'h8,     32'h0,  32'h100, 32'h0,  1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 32'h50,  32'h80,    32'h0,  32'h100, 32'h44, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h80,  32'h8,     32'h80, 32'h100, 32'h0,  4));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h84,  32'h0,     32'h80, 32'h100, 32'h0,  0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h88,  32'h8,     32'h80, 32'h100, 32'h0,  0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 32'h200, 32'h8,     32'h80, 32'h100, 32'h0,  1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 32'h110, 32'h1880,  32'h80, 32'h100, 32'h204, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h204, 32'h8,     32'h80, 32'h100, 32'h0,  4));
        tbl.push_back(mk(1, 0, 1, 1, 0, 32'h300, 32'hFFFF_FFFF, 32'h80, 32'h100, 32'h0, 2));
        tbl.push_back(mk(1, 1, 1, 0, 0, 32'h304, 32'h0,     32'h0,  32'h100, 32'h0,  1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h308, 32'h8,     32'h0,  32'h100, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h30C, 32'h8,     32'h80, 32'h101, 32'h0,  4));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h310, 32'h8,     32'h80, 32'h101, 32'h0,  1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 32'h314, 32'h8,     32'h0,  32'h100, 32'h88, 3));

        for (int i = 0; i < tbl.size(); i++)
            run_event(tbl[i], tbl[i].kind, $sformatf("vec%0d", i));

        // MIE clear: a pending timer with valid EX must be ignored for 20 cycles
        @(posedge clk); #1;
        apply(mk(1, 0, 0, 0, 1, 32'h400, 32'h0, 32'h80, 32'h100, 32'h0, 0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("mie0_c%0d", i), {hold_flag_o, clint_csr_we_o, int_assert_o}, 3'b000);
        end

        // reset asserted while in S_MCAUSE
        @(posedge clk); #1;
        apply(mk(1, 1, 0, 0, 0, 32'h500, 32'h8, 32'h0, 32'h100, 32'h0, 1));
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_mcause", {clint_csr_we_o, clint_csr_waddr_o}, {1'b1, 12'h342});
        ex_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {hold_flag_o, clint_csr_we_o, int_assert_o, |clint_csr_waddr_o,
                               |clint_csr_wdata_o, |int_addr_o}, '0);
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_c%0d", i), {hold_flag_o, clint_csr_we_o, int_assert_o}, 3'b000);
        end
        run_event(mk(1, 0, 1, 0, 0, 32'h600, 32'h8, 32'h0, 32'h100, 32'h0, 2), 2, "post_rst_ebreak");

        // randomized events against the reference model
        for (int n = 0; n < 40; n++) begin
            vec_t v;
            v = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                   1'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, 0);
            run_event(v, classify(v), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
